// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit with HI/LO registers and a busy counter.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO when idle. A multi-cycle result is
// held in a pending register and written to HI/LO on the edge where Busy drops.
// Optional build macro MDU_MADD_EN adds signed MADD/MSUB accumulation into HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [63:0] pend_reg;
  logic        pend_valid_reg;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, den_s, q_mag, r_mag, quot_s, rem_s;
  logic [31:0] den_u, quot_u, rem_u;
`ifdef MDU_MADD_EN
  logic [63:0] acc_add, acc_sub;
`endif

  // Busy is a direct flop output: high exactly while the counter is non-zero.
  assign Busy = (state_reg == ST_RUN);

  // Combinational arithmetic on the live operands; captured into pend_reg at accept.
  always_comb begin
    // Low 64 bits of sign-extended operands equal the signed 64-bit product.
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    // Signed divide done on magnitudes so that 0x80000000 / -1 wraps cleanly.
    a_mag  = A[31] ? (~A + 32'd1) : A;
    b_mag  = B[31] ? (~B + 32'd1) : B;
    den_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / den_s;
    r_mag  = a_mag % den_s;
    quot_s = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = A[31] ? (~r_mag + 32'd1) : r_mag;
    // Divisor forced non-zero; a zero divisor never commits anyway.
    den_u  = (B == 32'd0) ? 32'd1 : B;
    quot_u = A / den_u;
    rem_u  = A % den_u;
`ifdef MDU_MADD_EN
    acc_add = {HI, LO} + prod_s;
    acc_sub = {HI, LO} - prod_s;
`endif
  end

  // Sequencer: accept in IDLE, count down in RUN, commit pending result on 1->0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 4'd0;
      pend_reg       <= 64'd0;
      pend_valid_reg <= 1'b0;
      HI             <= 32'd0;
      LO             <= 32'd0;
    end else if (state_reg == ST_IDLE) begin
      if (Start) begin
        case (MDUOp)
          OP_MULT: begin
            pend_reg       <= prod_s;
            pend_valid_reg <= 1'b1;
            cnt_reg        <= MULT_LOAD;
            state_reg      <= ST_RUN;
          end
          OP_MULTU: begin
            pend_reg       <= prod_u;
            pend_valid_reg <= 1'b1;
            cnt_reg        <= MULT_LOAD;
            state_reg      <= ST_RUN;
          end
          OP_DIV: begin
            pend_reg       <= {rem_s, quot_s};
            pend_valid_reg <= (B != 32'd0);
            cnt_reg        <= DIV_LOAD;
            state_reg      <= ST_RUN;
          end
          OP_DIVU: begin
            pend_reg       <= {rem_u, quot_u};
            pend_valid_reg <= (B != 32'd0);
            cnt_reg        <= DIV_LOAD;
            state_reg      <= ST_RUN;
          end
          OP_MTHI: HI <= A;
          OP_MTLO: LO <= A;
`ifdef MDU_MADD_EN
          OP_MADD: begin
            pend_reg       <= acc_add;
            pend_valid_reg <= 1'b1;
            cnt_reg        <= MULT_LOAD;
            state_reg      <= ST_RUN;
          end
          OP_MSUB: begin
            pend_reg       <= acc_sub;
            pend_valid_reg <= 1'b1;
            cnt_reg        <= MULT_LOAD;
            state_reg      <= ST_RUN;
          end
`endif
          default: ;
        endcase
      end
    end else begin
      cnt_reg <= cnt_reg - 4'd1;
      if (cnt_reg == 4'd1) begin
        state_reg      <= ST_IDLE;
        pend_valid_reg <= 1'b0;
        if (pend_valid_reg) begin
          HI <= pend_reg[63:32];
          LO <= pend_reg[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus randomized bench for mdu_ctrl against a
// timestamp-based reference model. Honours MDU_MADD_EN like the design.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          edge_cnt = 0;
  int          m_done = 0;
  bit          m_commit = 1'b0;
  logic [63:0] m_res = 64'd0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  bit          started = 1'b0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: an accepted op finishes N edges later; Busy is "now before deadline".
  task automatic model_step();
    bit busy_before;
    int sa, sb;
    longint p, q, r;
    longint unsigned ua, ub;
    busy_before = (edge_cnt < m_done);
    edge_cnt++;
    started = 1'b1;
    if (reset) begin
      m_done = 0; m_commit = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (busy_before) begin
      if (edge_cnt == m_done && m_commit) begin
        m_hi = m_res[63:32]; m_lo = m_res[31:0];
      end
    end else if (Start) begin
      sa = A; sb = B; ua = A; ub = B;
      p = longint'(sa) * longint'(sb);
      $display("op=%0d A=%h B=%h edge=%0d", MDUOp, A, B, edge_cnt);
      case (MDUOp)
        4'd1: begin m_res = p; m_commit = 1'b1; m_done = edge_cnt + MULT_N; end
        4'd2: begin m_res = ua * ub; m_commit = 1'b1; m_done = edge_cnt + MULT_N; end
        4'd3: begin
          m_commit = (B != 0); m_done = edge_cnt + DIV_N;
          if (B != 0) begin
            q = longint'(sa) / longint'(sb); r = longint'(sa) % longint'(sb);
            m_res = {r[31:0], q[31:0]};
          end
        end
        4'd4: begin
          m_commit = (B != 0); m_done = edge_cnt + DIV_N;
          if (B != 0) m_res = {A % B, A / B};
        end
        4'd5: m_hi = A;
        4'd6: m_lo = A;
`ifdef MDU_MADD_EN
        4'd7: begin m_res = {m_hi, m_lo} + p; m_commit = 1'b1; m_done = edge_cnt + MULT_N; end
        4'd8: begin m_res = {m_hi, m_lo} - p; m_commit = 1'b1; m_done = edge_cnt + MULT_N; end
`endif
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle, mid-period, DUT against model.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("busy", {31'd0, Busy}, {31'd0, (edge_cnt < m_done)});
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
    end
  end

  // Issue one op, scramble operands afterwards, return number of busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [31:0] lo_save;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, n);
    chk("mult_len", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    chk("multu_len", n, 32'd5);
    chk("multu_hi", HI, 32'hFFFFFFFE);
    chk("multu_lo", LO, 32'h00000001);

    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    chk("div_len", n, 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    run_op(4'd4, 32'd7, 32'd0, n);
    chk("div0_len", n, 32'd10);
    chk("div0_hi", HI, 32'hFFFFFFFF);
    chk("div0_lo", LO, 32'hFFFFFFFD);

    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'h00000000);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    Start = 1'b1; MDUOp = 4'd5; A = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo_old", LO, 32'h80000000);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    MDUOp = 4'd6; A = 32'h9ABCDEF0;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mtlo_busy", {31'd0, Busy}, 32'd0);

    // DIV, ignored MTLO at cycle 3, reset at cycle 6
    @(negedge clk);
    Start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk); Start = 1'b0; MDUOp = 4'd0;
    @(negedge clk);
    @(negedge clk); Start = 1'b1; MDUOp = 4'd6; A = 32'h55;
    lo_save = 32'h9ABCDEF0;
    @(negedge clk); Start = 1'b0; MDUOp = 4'd0;
    chk("busy_mtlo_ign", LO, lo_save);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_nowrite_lo", LO, 32'd0);

    // MADD accumulate
    run_op(4'd5, 32'd0, 32'd0, n);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, n);
    run_op(4'd7, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
    chk("madd_len", n, 32'd5);
    chk("madd_hi", HI, 32'h00000001);
    chk("madd_lo", LO, 32'h00000000);
`else
    chk("madd_len", n, 32'd0);
    chk("madd_hi", HI, 32'h00000000);
    chk("madd_lo", LO, 32'hFFFFFFFF);
`endif

    // Randomized phase, including Start while busy and occasional reset
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      Start = ($urandom_range(0, 2) == 0);
      MDUOp = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: begin A = 32'h80000000; B = 32'hFFFFFFFF; end
        1: begin A = $urandom; B = 32'd0; end
        2: begin A = $urandom_range(0, 20); B = $urandom_range(0, 5); end
        default: begin A = $urandom; B = $urandom; end
      endcase
    end
    @(negedge clk);
    reset = 1'b0; Start = 1'b0; MDUOp = 4'd0;
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
